// File: rtl/ahb_split_ctrl.sv
// AHB slave-side SPLIT controller: splits transfers while the backend is busy and
// releases the split masters round-robin through HSPLITx once the backend frees up.
//
// state  | meaning
// IDLE   | ready, OKAY; samples address phases
// SPLIT1 | first SPLIT cycle, HREADYOUT low
// SPLIT2 | second SPLIT cycle, HREADYOUT high; address phase ignored
// WAIT   | locked/untracked transfer stalled until the backend is free
module ahb_split_ctrl #(
    parameter int NUM_MASTERS = 16,
    parameter int RELEASE_GAP = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [3:0]  HMASTER,
    input  logic        HMASTLOCK,
    input  logic        busy_i,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [15:0] HSPLITx,
    output logic [15:0] pending_o,
    output logic        accept_o
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic [1:0] {IDLE, SPLIT1, SPLIT2, WAIT} state_t;

    state_t      state;
    logic [3:0]  rr_ptr;
    logic [3:0]  gap_cnt;
    logic [3:0]  rel_idx;
    logic        rel_found;
    logic [4:0]  cand;
    logic        sample;
    logic        master_ok;
    logic        do_split;
    logic        rel_armed;
    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic        unused_htrans0;

    assign unused_htrans0 = HTRANS[0];
    assign sample    = HSEL & HTRANS[1] & HREADY;
    assign master_ok = ({1'b0, HMASTER} < 5'(NUM_MASTERS));
    assign do_split  = (state == IDLE) & sample & busy_i & ~HMASTLOCK & master_ok;
    assign set_vec   = do_split ? (16'(1) << HMASTER) : 16'h0000;
    assign rel_armed = ~busy_i & (pending_o != 16'h0000) & (gap_cnt == 4'd0);
    assign clr_vec   = (rel_armed & rel_found) ? (16'(1) << rel_idx) : 16'h0000;

    // Scan downward so the last hit is the nearest set bit above rr_ptr.
    always_comb begin
        rel_idx   = '0;
        rel_found = 1'b0;
        cand      = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = 5'({1'b0, rr_ptr}) + 5'(k);
            if (cand >= 5'(NUM_MASTERS))
                cand = cand - 5'(NUM_MASTERS);
            if (pending_o[cand[3:0]]) begin
                rel_idx   = cand[3:0];
                rel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
            accept_o  <= 1'b0;
        end else begin
            accept_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample) begin
                        if (!busy_i) begin
                            accept_o <= 1'b1;
                        end else if (!HMASTLOCK && master_ok) begin
                            state     <= SPLIT1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= RESP_SPLIT;
                        end else begin
                            state     <= WAIT;
                            HREADYOUT <= 1'b0;
                            HRESP     <= RESP_OKAY;
                        end
                    end
                end
                SPLIT1: begin
                    state     <= SPLIT2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_SPLIT;
                end
                SPLIT2: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_OKAY;
                end
                WAIT: begin
                    if (!busy_i) begin
                        state     <= IDLE;
                        HREADYOUT <= 1'b1;
                        accept_o  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_OKAY;
                end
            endcase
        end
    end

    // Release engine; a new split (set) wins over a concurrent clear of the same bit.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pending_o <= 16'h0000;
            HSPLITx   <= 16'h0000;
            rr_ptr    <= 4'(NUM_MASTERS - 1);
            gap_cnt   <= 4'd0;
        end else begin
            pending_o <= (pending_o & ~clr_vec) | set_vec;
            HSPLITx   <= clr_vec;
            if (rel_armed && rel_found) begin
                rr_ptr  <= rel_idx;
                gap_cnt <= 4'(RELEASE_GAP);
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// Self-checking bench for ahb_split_ctrl: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_ahb_split_ctrl;

    localparam int N   = 16;
    localparam int GAP = 2;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;
    logic        busy_i;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [15:0] HSPLITx;
    logic [15:0] pending_o;
    logic        accept_o;

    ahb_split_ctrl #(.NUM_MASTERS(N), .RELEASE_GAP(GAP)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK),
        .busy_i    (busy_i),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HSPLITx   (HSPLITx),
        .pending_o (pending_o),
        .accept_o  (accept_o)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    logic [15:0] m_pend;
    int          m_last;
    int          m_gap;
    bit          m_wait;
    logic [2:0]  rsp_q[$];
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic        e_acc;
    logic [15:0] e_split;

    // directed-test scratch
    int          tp[$];
    logic [15:0] seen;
    logic [15:0] first_rel;
    logic [15:0] second_rel;
    int          lo_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_step();
        logic [2:0] r;
        if (HRESET) begin
            m_pend = '0; m_last = N - 1; m_gap = 0; m_wait = 0;
            rsp_q.delete();
            e_rdy = 1'b1; e_resp = 2'b00; e_acc = 1'b0; e_split = '0;
            return;
        end
        e_split = '0;
        if (!busy_i && m_pend != 0 && m_gap == 0) begin
            for (int j = 1; j <= N; j++) begin
                int c;
                c = (m_last + j) % N;
                if (m_pend[c]) begin
                    e_split = 16'(1) << c;
                    m_last  = c;
                    break;
                end
            end
            m_pend = m_pend & ~e_split;
            m_gap  = GAP;
        end else if (m_gap > 0) begin
            m_gap--;
        end
        e_acc = 1'b0; e_rdy = 1'b1; e_resp = 2'b00;
        if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            e_rdy  = r[2];
            e_resp = r[1:0];
        end else if (m_wait) begin
            if (busy_i) e_rdy = 1'b0;
            else begin
                m_wait = 0;
                e_acc  = 1'b1;
            end
        end else if (HSEL && HTRANS[1] && HREADY) begin
            if (!busy_i) begin
                e_acc = 1'b1;
            end else if (!HMASTLOCK && int'(HMASTER) < N) begin
                m_pend[HMASTER] = 1'b1;
                e_rdy  = 1'b0;
                e_resp = 2'b11;
                rsp_q.push_back(3'b111);
                rsp_q.push_back(3'b100);
            end else begin
                m_wait = 1;
                e_rdy  = 1'b0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge HCLK);
        model_step();
        cyc++;
        #1;
        chk("hreadyout", 32'(HREADYOUT), 32'(e_rdy));
        chk("hresp",     32'(HRESP),     32'(e_resp));
        chk("accept",    32'(accept_o),  32'(e_acc));
        chk("hsplit",    32'(HSPLITx),   32'(e_split));
        chk("pending",   32'(pending_o), 32'(m_pend));
    endtask

    task automatic xfer(input logic [3:0] m, input logic lock);
        HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1; HMASTER = m; HMASTLOCK = lock;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HMASTLOCK = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
        HMASTER = '0; HMASTLOCK = 1'b0; busy_i = 1'b0;
        tick(); tick();
        chk("rst_rdy", 32'(HREADYOUT), 32'd1);
        chk("rst_pend", 32'(pending_o), 32'd0);
        HRESET = 1'b0;
        tick();

        // 1: zero-wait OKAY
        xfer(4'd3, 1'b0);
        chk("t1_acc", 32'(accept_o), 32'd1);
        chk("t1_split", 32'(HSPLITx), 32'd0);
        tick();

        // 2: split master 5 then release
        busy_i = 1'b1;
        xfer(4'd5, 1'b0);
        chk("t2_rdy0", 32'(HREADYOUT), 32'd0);
        chk("t2_resp0", 32'(HRESP), 32'd3);
        tick();
        chk("t2_rdy1", 32'(HREADYOUT), 32'd1);
        chk("t2_resp1", 32'(HRESP), 32'd3);
        chk("t2_pend", 32'(pending_o), 32'h0020);
        tick();
        busy_i = 1'b0;
        tick();
        chk("t2_rel", 32'(HSPLITx), 32'h0020);
        tick();
        chk("t2_rel_off", 32'(HSPLITx), 32'h0);
        chk("t2_pend0", 32'(pending_o), 32'h0);

        // 3: three splits, spaced releases
        busy_i = 1'b1;
        xfer(4'd2, 1'b0);  tick(); tick();
        xfer(4'd7, 1'b0);  tick(); tick();
        xfer(4'd12, 1'b0); tick(); tick();
        busy_i = 1'b0;
        seen = '0;
        tp.delete();
        for (int i = 0; i < 14; i++) begin
            tick();
            if (HSPLITx != 0) begin
                tp.push_back(cyc);
                seen = seen | HSPLITx;
            end
        end
        chk("t3_npulse", 32'(tp.size()), 32'd3);
        if (tp.size() == 3) begin
            chk("t3_gap_a", 32'(tp[1] - tp[0]), 32'd3);
            chk("t3_gap_b", 32'(tp[2] - tp[1]), 32'd3);
        end
        chk("t3_bits", 32'(seen), 32'h1084);

        // 4: locked transfer while busy waits, never split
        busy_i = 1'b1;
        lo_cnt = 0;
        xfer(4'd1, 1'b1);
        if (!HREADYOUT) lo_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!HREADYOUT) lo_cnt++;
        end
        busy_i = 1'b0;
        tick();
        chk("t4_lowcnt", 32'(lo_cnt), 32'd5);
        chk("t4_acc", 32'(accept_o), 32'd1);
        chk("t4_pend", 32'(pending_o), 32'd0);
        tick();

        // 5: rr_ptr at 7 -> master 9 before master 3
        busy_i = 1'b1;
        xfer(4'd7, 1'b0); tick(); tick();
        busy_i = 1'b0;
        tick(); tick(); tick(); tick();
        busy_i = 1'b1;
        xfer(4'd3, 1'b0); tick(); tick();
        xfer(4'd9, 1'b0); tick(); tick();
        chk("t5_pend", 32'(pending_o), 32'h0208);
        busy_i = 1'b0;
        first_rel = '0; second_rel = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (HSPLITx != 0) begin
                if (first_rel == 0) first_rel = HSPLITx;
                else if (second_rel == 0) second_rel = HSPLITx;
            end
        end
        chk("t5_first", 32'(first_rel), 32'h0200);
        chk("t5_second", 32'(second_rel), 32'h0008);

        // 6: reset with four masters pending
        busy_i = 1'b1;
        for (int m = 8; m < 12; m++) begin
            xfer(4'(m), 1'b0); tick(); tick();
        end
        chk("t6_pend", 32'(pending_o), 32'h0F00);
        busy_i = 1'b0;
        HRESET = 1'b1;
        tick();
        chk("t6_pend0", 32'(pending_o), 32'h0);
        chk("t6_split0", 32'(HSPLITx), 32'h0);
        chk("t6_rdy", 32'(HREADYOUT), 32'd1);
        chk("t6_resp", 32'(HRESP), 32'd0);
        HRESET = 1'b0;
        tick();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            HSEL      = ($urandom_range(0, 1) == 1);
            HTRANS    = 2'($urandom_range(0, 3));
            HREADY    = ($urandom_range(0, 7) != 0);
            HMASTER   = 4'($urandom_range(0, 15));
            HMASTLOCK = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) busy_i = ~busy_i;
            HRESET    = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
